// File: rtl/difftest_arch_reg_tracker.sv
// -----------------------------------------------------------------------------
// difftest_arch_reg_tracker
//
// Shadow architectural register file for difftest export. Commit-time write
// ports update a shadow copy of the register file and mark the written
// registers dirty. On a snapshot request the post-write shadow and the dirty
// vector are frozen into a snapshot buffer, which is then streamed out LANES
// registers per beat over a valid/ready channel. In delta mode only beats that
// contain at least one dirty register are sent.
//
// Ports:
//   io_clock       sole clock
//   io_reset       synchronous, active-high reset
//   io_coreid      hart id, latched when a snapshot is captured
//   io_wen         per-port commit write enable
//   io_waddr       per-port register index, port p at [p*AW +: AW]
//   io_wdata       per-port write data, port p at [p*XLEN +: XLEN]
//   io_snap_req    snapshot request (pulse or level)
//   io_snap_busy   snapshot being streamed or just finished (SEND/DONE)
//   io_out_valid   beat valid
//   io_out_ready   consumer ready
//   io_out_coreid  hart id captured with the snapshot
//   io_out_index   register index of lane 0 (multiple of LANES)
//   io_out_data    lane k = register io_out_index + k
//   io_out_mask    lane k carries a dirty (delta) or valid (full) register
//   io_out_last    final beat of the snapshot
//   io_snap_done   one-cycle pulse after the last handshake
// -----------------------------------------------------------------------------
module difftest_arch_reg_tracker #(
    parameter int XLEN       = 64,
    parameter int NUM_REGS   = 32,
    parameter int NUM_WB     = 2,
    parameter int LANES      = 4,
    parameter int ZERO_REG   = 0,
    parameter int DELTA_MODE = 0,
    parameter int AW         = $clog2(NUM_REGS)
) (
    input  logic                   io_clock,
    input  logic                   io_reset,
    input  logic [7:0]             io_coreid,
    input  logic [NUM_WB-1:0]      io_wen,
    input  logic [NUM_WB*AW-1:0]   io_waddr,
    input  logic [NUM_WB*XLEN-1:0] io_wdata,
    input  logic                   io_snap_req,
    output logic                   io_snap_busy,
    output logic                   io_out_valid,
    input  logic                   io_out_ready,
    output logic [7:0]             io_out_coreid,
    output logic [AW-1:0]          io_out_index,
    output logic [LANES*XLEN-1:0]  io_out_data,
    output logic [LANES-1:0]       io_out_mask,
    output logic                   io_out_last,
    output logic                   io_snap_done
);

    localparam int NUM_BEATS = NUM_REGS / LANES;
    localparam int BW        = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;

    // Register 0 of an integer file is hard-wired zero and therefore never
    // valid/dirty; every other register is. Used both as the dirty reset value
    // and as the fixed snapshot mask of full (non-delta) snapshots.
    localparam logic [NUM_REGS-1:0] FULL_MASK =
        (ZERO_REG != 0) ? {{(NUM_REGS-1){1'b1}}, 1'b0} : {NUM_REGS{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    // Live shadow file and the view of it after this cycle's commit writes.
    logic [XLEN-1:0]     shadow_q    [NUM_REGS];
    logic [XLEN-1:0]     shadow_post [NUM_REGS];
    logic [NUM_REGS-1:0] dirty_q;
    logic [NUM_REGS-1:0] dirty_post;

    // Frozen snapshot being streamed.
    logic [XLEN-1:0]     snap_data_q [NUM_REGS];
    logic [NUM_REGS-1:0] snap_mask_q;
    logic [7:0]          coreid_q;
    logic [BW-1:0]       beat_q;
    logic                pending_q;

    logic [NUM_REGS-1:0] cap_mask;
    logic [BW-1:0]       first_beat;
    logic [BW-1:0]       beat_next;
    logic                has_next;
    logic                capture;
    logic                fire;
    logic [AW-1:0]       cur_index;

    // -------------------------------------------------------------------------
    // Commit write merge. Ports are applied in ascending order so the highest
    // port index wins on a same-cycle, same-address collision.
    // -------------------------------------------------------------------------
    always_comb begin : write_merge
        // NOTE: every variable gets a default before any conditional update so
        // that no path leaves it unassigned and no latch is inferred.
        dirty_post = dirty_q;
        for (int r = 0; r < NUM_REGS; r++) begin
            shadow_post[r] = shadow_q[r];
        end
        for (int p = 0; p < NUM_WB; p++) begin
            if (io_wen[p] && !((ZERO_REG != 0) && (io_waddr[p*AW +: AW] == '0))) begin
                shadow_post[io_waddr[p*AW +: AW]] = io_wdata[p*XLEN +: XLEN];
                dirty_post[io_waddr[p*AW +: AW]]  = 1'b1;
            end
        end
    end

    // Mask frozen at capture: the dirty vector in delta mode, otherwise every
    // architecturally meaningful register.
    assign cap_mask = (DELTA_MODE != 0) ? dirty_post : FULL_MASK;

    // -------------------------------------------------------------------------
    // Beat selection. Delta mode priority-finds the lowest non-empty beat, both
    // at capture and after each handshake, so empty beats cost no cycles. With
    // nothing dirty, beat 0 is sent alone (mask 0, last 1).
    // -------------------------------------------------------------------------
    always_comb begin : beat_scan
        first_beat = '0;
        beat_next  = '0;
        has_next   = 1'b0;
        if (DELTA_MODE != 0) begin
            // Descending scan: the lowest matching beat is assigned last.
            for (int b = NUM_BEATS - 1; b >= 0; b--) begin
                if (|cap_mask[b*LANES +: LANES]) begin
                    first_beat = BW'(b);
                end
                if ((|snap_mask_q[b*LANES +: LANES]) && (b > int'(beat_q))) begin
                    beat_next = BW'(b);
                    has_next  = 1'b1;
                end
            end
        end else begin
            beat_next = beat_q + BW'(1);
            has_next  = (beat_q != BW'(NUM_BEATS - 1));
        end
    end

    // -------------------------------------------------------------------------
    // Control FSM
    // -------------------------------------------------------------------------
    always_comb begin : fsm_next
        state_d = state_q;
        capture = 1'b0;
        fire    = (state_q == S_SEND) && io_out_ready;
        unique case (state_q)
            S_IDLE: begin
                if (io_snap_req) begin
                    capture = 1'b1;
                    state_d = S_SEND;
                end
            end
            S_SEND: begin
                if (fire && !has_next) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                // A queued request (or one arriving now) is served back-to-back
                // with DONE-cycle writes included.
                if (pending_q || io_snap_req) begin
                    capture = 1'b1;
                    state_d = S_SEND;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge io_clock) begin : fsm_state
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values, independent of statement order.
        if (io_reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -------------------------------------------------------------------------
    // Shadow file, dirty tracking and snapshot buffer
    // -------------------------------------------------------------------------
    always_ff @(posedge io_clock) begin : datapath
        if (io_reset) begin
            // NOTE: the register arrays are reset explicitly because the shadow
            // must read as zero after reset; this keeps them in flops rather
            // than RAM, which is intended for a 32-entry file.
            for (int r = 0; r < NUM_REGS; r++) begin
                shadow_q[r]    <= '0;
                snap_data_q[r] <= '0;
            end
            dirty_q     <= FULL_MASK;
            snap_mask_q <= '0;
            coreid_q    <= '0;
            beat_q      <= '0;
            pending_q   <= 1'b0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                shadow_q[r] <= shadow_post[r];
            end

            if (capture) begin
                // Snapshot includes this cycle's writes; their dirty bits are
                // consumed by this snapshot.
                for (int r = 0; r < NUM_REGS; r++) begin
                    snap_data_q[r] <= shadow_post[r];
                end
                snap_mask_q <= cap_mask;
                coreid_q    <= io_coreid;
                beat_q      <= first_beat;
                dirty_q     <= '0;
                pending_q   <= 1'b0;
            end else begin
                dirty_q <= dirty_post;
                if (fire && has_next) begin
                    beat_q <= beat_next;
                end
                // Only one request is queued; repeats merge into it.
                if (io_snap_req && (state_q == S_SEND)) begin
                    pending_q <= 1'b1;
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Output channel. Everything is driven straight from frozen state, so the
    // beat is inherently stable while the consumer stalls.
    // -------------------------------------------------------------------------
    assign cur_index    = AW'(beat_q) * AW'(LANES);
    assign io_snap_busy = (state_q != S_IDLE);
    assign io_out_valid = (state_q == S_SEND);
    assign io_snap_done = (state_q == S_DONE);

    always_comb begin : out_mux
        io_out_index  = '0;
        io_out_data   = '0;
        io_out_mask   = '0;
        io_out_last   = 1'b0;
        io_out_coreid = '0;
        if (state_q == S_SEND) begin
            io_out_index  = cur_index;
            io_out_mask   = snap_mask_q[cur_index +: LANES];
            io_out_last   = !has_next;
            io_out_coreid = coreid_q;
            for (int k = 0; k < LANES; k++) begin
                io_out_data[k*XLEN +: XLEN] = snap_data_q[cur_index + AW'(k)];
            end
        end
    end

endmodule

// File: tb/tb_difftest_arch_reg_tracker.sv
// -----------------------------------------------------------------------------
// Bench for difftest_arch_reg_tracker. Three instances share clock, reset and
// the commit write bus: full mode, delta mode, and full mode with a hard-wired
// zero register. A reference model builds the expected beat list of every
// snapshot when the request is driven; a monitor pops and compares it on each
// handshake. Hand-written sequences cover timing, backpressure, queued
// requests and reset in the middle of a snapshot.
// -----------------------------------------------------------------------------
module tb_difftest_arch_reg_tracker;

    localparam int XLEN  = 64;
    localparam int NR    = 32;
    localparam int NW    = 2;
    localparam int LANES = 4;
    localparam int AW    = 5;

    typedef struct {
        logic [AW-1:0]         idx;
        logic [LANES-1:0]      mask;
        logic [LANES*XLEN-1:0] data;
        logic                  last;
        logic [7:0]            core;
    } beat_t;

    typedef struct {
        logic [1:0]  en;
        logic [4:0]  a0;
        logic [63:0] d0;
        logic [4:0]  a1;
        logic [63:0] d1;
        logic [4:0]  chk_reg;
        logic [63:0] chk_val;
    } wvec_t;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [7:0]            coreid;
    logic [NW-1:0]         wen;
    logic [NW*AW-1:0]      waddr;
    logic [NW*XLEN-1:0]    wdata;
    logic                  ready;
    logic [2:0]            snap_req;
    logic [2:0]            busy, valid, last, done;
    logic [7:0]            ocore [3];
    logic [AW-1:0]         oidx  [3];
    logic [LANES*XLEN-1:0] odata [3];
    logic [LANES-1:0]      omask [3];

    int n_checks = 0;
    int n_fail   = 0;

    logic [63:0] m_reg    [3][NR];
    logic [NR-1:0] m_dirty [3];
    logic [63:0] seen_reg [3][NR];
    logic [3:0]  first_mask [3];
    beat_t q0[$], q1[$], q2[$];
    wvec_t vecs [5];

    always #5 clk = ~clk;

    difftest_arch_reg_tracker #(.DELTA_MODE(0), .ZERO_REG(0)) dut_full (
        .io_clock(clk), .io_reset(rst), .io_coreid(coreid), .io_wen(wen),
        .io_waddr(waddr), .io_wdata(wdata), .io_snap_req(snap_req[0]),
        .io_snap_busy(busy[0]), .io_out_valid(valid[0]), .io_out_ready(ready),
        .io_out_coreid(ocore[0]), .io_out_index(oidx[0]), .io_out_data(odata[0]),
        .io_out_mask(omask[0]), .io_out_last(last[0]), .io_snap_done(done[0])
    );

    difftest_arch_reg_tracker #(.DELTA_MODE(1), .ZERO_REG(0)) dut_delta (
        .io_clock(clk), .io_reset(rst), .io_coreid(coreid), .io_wen(wen),
        .io_waddr(waddr), .io_wdata(wdata), .io_snap_req(snap_req[1]),
        .io_snap_busy(busy[1]), .io_out_valid(valid[1]), .io_out_ready(ready),
        .io_out_coreid(ocore[1]), .io_out_index(oidx[1]), .io_out_data(odata[1]),
        .io_out_mask(omask[1]), .io_out_last(last[1]), .io_snap_done(done[1])
    );

    difftest_arch_reg_tracker #(.DELTA_MODE(0), .ZERO_REG(1)) dut_zero (
        .io_clock(clk), .io_reset(rst), .io_coreid(coreid), .io_wen(wen),
        .io_waddr(waddr), .io_wdata(wdata), .io_snap_req(snap_req[2]),
        .io_snap_busy(busy[2]), .io_out_valid(valid[2]), .io_out_ready(ready),
        .io_out_coreid(ocore[2]), .io_out_index(oidx[2]), .io_out_data(odata[2]),
        .io_out_mask(omask[2]), .io_out_last(last[2]), .io_snap_done(done[2])
    );

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model ----------------
    task automatic model_reset();
        for (int d = 0; d < 3; d++) begin
            for (int i = 0; i < NR; i++) m_reg[d][i] = '0;
            m_dirty[d] = '1;
        end
        m_dirty[2][0] = 1'b0;
    endtask

    task automatic model_write(input logic [1:0] en, input logic [4:0] a0, input logic [63:0] d0,
                               input logic [4:0] a1, input logic [63:0] d1);
        logic [4:0]  a;
        logic [63:0] v;
        for (int d = 0; d < 3; d++) begin
            for (int p = 0; p < 2; p++) begin
                a = (p == 0) ? a0 : a1;
                v = (p == 0) ? d0 : d1;
                if (en[p] && !(d == 2 && a == 5'd0)) begin
                    m_reg[d][a]   = v;
                    m_dirty[d][a] = 1'b1;
                end
            end
        end
    endtask

    task automatic push_snap(input int d);
        beat_t tmp[$];
        beat_t b;
        bit delta;
        delta = (d == 1);
        for (int bb = 0; bb < NR / LANES; bb++) begin
            b.idx  = AW'(bb * LANES);
            b.core = coreid;
            b.last = 1'b0;
            for (int k = 0; k < LANES; k++) b.data[k*XLEN +: XLEN] = m_reg[d][bb*LANES + k];
            if (delta)                 b.mask = m_dirty[d][bb*LANES +: LANES];
            else if (d == 2 && bb == 0) b.mask = 4'b1110;
            else                       b.mask = 4'b1111;
            if (!delta || b.mask != 4'b0000) tmp.push_back(b);
        end
        if (tmp.size() == 0) begin
            b.idx  = '0;
            b.mask = 4'b0000;
            b.core = coreid;
            for (int k = 0; k < LANES; k++) b.data[k*XLEN +: XLEN] = m_reg[d][k];
            tmp.push_back(b);
        end
        tmp[tmp.size()-1].last = 1'b1;
        foreach (tmp[i]) begin
            case (d)
                0:       q0.push_back(tmp[i]);
                1:       q1.push_back(tmp[i]);
                default: q2.push_back(tmp[i]);
            endcase
        end
        m_dirty[d] = '0;
    endtask

    // ---------------- scoreboard monitor ----------------
    task automatic mon_beat(input int d);
        beat_t e;
        bit    got;
        got = 1'b0;
        case (d)
            0:       if (q0.size() > 0) begin e = q0.pop_front(); got = 1'b1; end
            1:       if (q1.size() > 0) begin e = q1.pop_front(); got = 1'b1; end
            default: if (q2.size() > 0) begin e = q2.pop_front(); got = 1'b1; end
        endcase
        if (!got) begin
            check($sformatf("d%0d unexpected beat idx %0d", d, oidx[d]), 1, 0);
        end else begin
            check($sformatf("d%0d beat idx", d), oidx[d], e.idx);
            check($sformatf("d%0d beat mask @%0d", d, e.idx), omask[d], e.mask);
            check($sformatf("d%0d beat data @%0d", d, e.idx), odata[d], e.data);
            check($sformatf("d%0d beat last @%0d", d, e.idx), last[d], e.last);
            check($sformatf("d%0d beat coreid @%0d", d, e.idx), ocore[d], e.core);
        end
        for (int k = 0; k < LANES; k++) seen_reg[d][int'(oidx[d]) + k] = odata[d][k*XLEN +: XLEN];
        if (oidx[d] == '0) first_mask[d] = omask[d];
    endtask

    always @(negedge clk) begin
        if (!rst && ready) begin
            for (int d = 0; d < 3; d++) begin
                if (valid[d]) mon_beat(d);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic set_wr(input logic [1:0] en, input logic [4:0] a0, input logic [63:0] d0,
                          input logic [4:0] a1, input logic [63:0] d1);
        wen   = en;
        waddr = {a1, a0};
        wdata = {d1, d0};
        model_write(en, a0, d0, a1, d1);
    endtask

    task automatic hand_beat(input int d, input string tag, input logic [4:0] i,
                             input logic [3:0] m, input logic l);
        check({tag, " valid"}, valid[d], 1);
        check({tag, " index"}, oidx[d], i);
        check({tag, " mask"},  omask[d], m);
        check({tag, " last"},  last[d], l);
    endtask

    task automatic wait_idle(output int ndone);
        int c;
        ndone = 0;
        for (c = 0; c < 200 && busy != 3'b000; c++) begin
            tick();
            ndone += int'(done[0]);
        end
        check("wait_idle timeout busy", busy, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int nd;

        vecs[0] = '{2'b11, 5'd5,  64'h1111,             5'd5,  64'h2222,             5'd5,  64'h2222};
        vecs[1] = '{2'b01, 5'd7,  64'ha5a5_a5a5_0000_0007, 5'd0, 64'h0,              5'd7,  64'ha5a5_a5a5_0000_0007};
        vecs[2] = '{2'b10, 5'd0,  64'h0,                5'd31, 64'hffff_ffff_ffff_ffff, 5'd31, 64'hffff_ffff_ffff_ffff};
        vecs[3] = '{2'b11, 5'd12, 64'h1,                5'd13, 64'h2,                5'd12, 64'h1};
        vecs[4] = '{2'b11, 5'd0,  64'hdead,             5'd1,  64'hbeef,             5'd0,  64'hdead};

        rst = 1'b1; coreid = '0; wen = '0; waddr = '0; wdata = '0; ready = 1'b1; snap_req = '0;
        for (int d = 0; d < 3; d++) first_mask[d] = 4'hF;
        model_reset();
        repeat (3) tick();

        // Reset state
        for (int d = 0; d < 3; d++) begin
            check($sformatf("rst d%0d valid", d), valid[d], 0);
            check($sformatf("rst d%0d busy", d),  busy[d], 0);
            check($sformatf("rst d%0d done", d),  done[d], 0);
            check($sformatf("rst d%0d last", d),  last[d], 0);
            check($sformatf("rst d%0d index", d), oidx[d], 0);
            check($sformatf("rst d%0d mask", d),  omask[d], 0);
            check($sformatf("rst d%0d data", d),  odata[d], 0);
            check($sformatf("rst d%0d coreid", d), ocore[d], 0);
        end
        rst = 1'b0;
        tick();

        // Full snapshot after reset: 8 back-to-back beats, done one cycle later.
        coreid = 8'h11;
        snap_req = 3'b011;
        push_snap(0);
        push_snap(1);
        tick();
        snap_req = '0;
        for (int i = 0; i < 8; i++) begin
            hand_beat(0, $sformatf("full beat%0d", i), 5'(i * 4), 4'hF, (i == 7));
            tick();
        end
        check("full done pulse", done[0], 1);
        check("full valid after last", valid[0], 0);
        tick();
        check("full done one cycle", done[0], 0);
        check("full busy cleared", busy[0], 0);

        // Table-driven commit writes, then one snapshot on every instance.
        for (int i = 0; i < 5; i++) begin
            set_wr(vecs[i].en, vecs[i].a0, vecs[i].d0, vecs[i].a1, vecs[i].d1);
            tick();
            wen = '0;
        end
        coreid = 8'h5a;
        snap_req = 3'b111;
        push_snap(0); push_snap(1); push_snap(2);
        tick();
        snap_req = '0;
        wait_idle(nd);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("vec%0d r%0d", i, vecs[i].chk_reg), seen_reg[0][vecs[i].chk_reg], vecs[i].chk_val);
        end
        check("zero r0 lane", seen_reg[2][0], 64'h0);
        check("zero r0 mask bit", first_mask[2][0], 0);
        check("zero r1 lane", seen_reg[2][1], 64'hbeef);

        // Delta snapshot: r2, r9, r30 dirty.
        set_wr(2'b11, 5'd2, 64'h22, 5'd9, 64'h99);
        tick();
        set_wr(2'b01, 5'd30, 64'h3030, 5'd0, 64'h0);
        tick();
        wen = '0;
        snap_req = 3'b010;
        push_snap(1);
        tick();
        snap_req = '0;
        hand_beat(1, "delta b0", 5'd0, 4'b0100, 1'b0);
        tick();
        hand_beat(1, "delta b8", 5'd8, 4'b0010, 1'b0);
        tick();
        hand_beat(1, "delta b28", 5'd28, 4'b0100, 1'b1);
        tick();
        check("delta done", done[1], 1);
        tick();
        snap_req = 3'b010;
        push_snap(1);
        tick();
        snap_req = '0;
        hand_beat(1, "delta empty", 5'd0, 4'b0000, 1'b1);
        tick();
        check("delta empty done", done[1], 1);
        tick();

        // Backpressure 1,0,0,1 with a write to r3 mid-snapshot.
        set_wr(2'b11, 5'd4, 64'h44, 5'd20, 64'h2020);
        tick();
        wen = '0;
        snap_req = 3'b010;
        push_snap(1);
        tick();
        snap_req = '0;
        hand_beat(1, "bp s1", 5'd4, 4'b0001, 1'b0);
        check("bp s1 data", odata[1][63:0], 64'h44);
        tick();
        hand_beat(1, "bp s2", 5'd20, 4'b0001, 1'b1);
        ready = 1'b0;
        set_wr(2'b01, 5'd3, 64'h333, 5'd0, 64'h0);
        tick();
        wen = '0;
        hand_beat(1, "bp s3 stalled", 5'd20, 4'b0001, 1'b1);
        check("bp s3 data", odata[1][63:0], 64'h2020);
        tick();
        hand_beat(1, "bp s4 stalled", 5'd20, 4'b0001, 1'b1);
        check("bp s4 data", odata[1][63:0], 64'h2020);
        ready = 1'b1;
        tick();
        check("bp done", done[1], 1);
        tick();
        snap_req = 3'b010;
        push_snap(1);
        tick();
        snap_req = '0;
        hand_beat(1, "bp r3 next", 5'd0, 4'b1000, 1'b1);
        check("bp r3 data", odata[1][255:192], 64'h333);
        tick();
        check("bp r3 done", done[1], 1);
        tick();

        // Requests while busy: merged into one extra back-to-back snapshot.
        coreid = 8'h22;
        snap_req = 3'b001;
        push_snap(0);
        tick();
        snap_req = '0;
        for (int c = 1; c <= 8; c++) begin
            if (c == 1) coreid = 8'h33;
            snap_req[0] = (c == 2 || c == 4);
            if (c == 2) push_snap(0);
            hand_beat(0, $sformatf("busy s%0d", c), 5'((c - 1) * 4), 4'hF, (c == 8));
            tick();
        end
        snap_req = '0;
        check("busy done pulse", done[0], 1);
        check("busy during done", busy[0], 1);
        tick();
        hand_beat(0, "pending start", 5'd0, 4'hF, 1'b0);
        check("pending coreid", ocore[0], 8'h33);
        wait_idle(nd);
        check("pending done count", nd, 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("no third snapshot %0d", i), valid[0], 0);
        end

        // Reset in the middle of a snapshot.
        coreid = 8'h44;
        snap_req = 3'b100;
        push_snap(2);
        tick();
        snap_req = '0;
        hand_beat(2, "rst s1", 5'd0, 4'b1110, 1'b0);
        tick();
        hand_beat(2, "rst s2", 5'd4, 4'hF, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst abort valid", valid[2], 0);
        check("rst abort done", done[2], 0);
        check("rst abort busy", busy[2], 0);
        q2.delete();
        model_reset();
        nd = 0;
        repeat (5) begin
            tick();
            nd += int'(done[2]);
        end
        check("rst no done pulse", nd, 0);

        // Recovery after reset: a full, all-zero snapshot.
        coreid = 8'h77;
        snap_req = 3'b001;
        push_snap(0);
        tick();
        snap_req = '0;
        wait_idle(nd);

        check("q0 drained", q0.size(), 0);
        check("q1 drained", q1.size(), 0);
        check("q2 drained", q2.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
